// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared control-word layout for the RV32I pipeline
//
// Purpose: bit positions of the 8-bit decoded control word, its packed
// struct view, and the all-zero bubble control word.
package core_pkg;

    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
//
// Purpose: flags when the instruction in ID needs a register that the load
// currently in EX has not produced yet.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rd_i   : the instruction currently in EX
//   id_valid_i, id_rs1/rs2_i, id_use_*_i : the instruction currently in ID
//   flush_i, hold_i                      : suppress the stall (flush or freeze wins)
//   stall_o                              : freeze PC and IF/ID, bubble into EX
module load_use_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic       flush_i,
    input  logic       hold_i,
    output logic       stall_o
);

    logic rs_match;

    assign rs_match = (id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                      (id_use_rs2_i && (id_rs2_i == ex_rd_i));

    // A load into x0 never produces a value anyone waits for.
    assign stall_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                     id_valid_i && rs_match && !flush_i && !hold_i;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
//
// Purpose: registers decoded ID operands/controls for EX, inserting bubbles on
// flush or load-use stall, freezing on hold, and counting load-use bubbles.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   id_*_i                : decoded instruction from ID
//   flush_i               : branch taken in EX, squash the ID instruction
//   hold_i                : downstream wait, freeze all ID/EX state
//   ex_*_o                : registered copies presented to EX / forwarding
//   stall_o               : load-use stall request for PC and IF/ID
//   stall_cnt_o           : saturating count of load-use bubbles
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [XLEN-1:0]  id_rdata1_i,
    input  logic [XLEN-1:0]  id_rdata2_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [7:0]       id_ctrl_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             ex_valid_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_rdata1_o,
    output logic [XLEN-1:0]  ex_rdata2_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [4:0]       ex_rs1_o,
    output logic [4:0]       ex_rs2_o,
    output logic [4:0]       ex_rd_o,
    output logic [7:0]       ex_ctrl_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic             valid_q,  valid_d;
    logic [XLEN-1:0]  pc_q,     pc_d;
    logic [XLEN-1:0]  rdata1_q, rdata1_d;
    logic [XLEN-1:0]  rdata2_q, rdata2_d;
    logic [XLEN-1:0]  imm_q,    imm_d;
    logic [4:0]       rs1_q,    rs1_d;
    logic [4:0]       rs2_q,    rs2_d;
    logic [4:0]       rd_q,     rd_d;
    ctrl_t            ctrl_q,   ctrl_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             stall;

    load_use_detect u_load_use_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (rd_q),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .flush_i       (flush_i),
        .hold_i        (hold_i),
        .stall_o       (stall)
    );

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;

        if (flush_i || (!hold_i && stall)) begin
            // Bubble: everything zero so forwarding never matches it.
            valid_d  = 1'b0;
            pc_d     = '0;
            rdata1_d = '0;
            rdata2_d = '0;
            imm_d    = '0;
            rs1_d    = 5'd0;
            rs2_d    = 5'd0;
            rd_d     = 5'd0;
            ctrl_d   = BUBBLE_CTRL;
            // stall is already gated by flush, so only real load-use bubbles count.
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!hold_i) begin
            valid_d  = id_valid_i;
            pc_d     = id_pc_i;
            rdata1_d = id_rdata1_i;
            rdata2_d = id_rdata2_i;
            imm_d    = id_imm_i;
            rs1_d    = id_rs1_i;
            rs2_d    = id_rs2_i;
            rd_d     = id_rd_i;
            ctrl_d   = id_valid_i ? ctrl_t'(id_ctrl_i) : BUBBLE_CTRL;
            // Forwarding trusts reg_write alone, so writes to x0 are dropped here.
            if (id_rd_i == 5'd0) begin
                ctrl_d.reg_write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            rd_q     <= 5'd0;
            ctrl_q   <= BUBBLE_CTRL;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid_o  = valid_q;
    assign ex_pc_o     = pc_q;
    assign ex_rdata1_o = rdata1_q;
    assign ex_rdata2_o = rdata2_q;
    assign ex_imm_o    = imm_q;
    assign ex_rs1_o    = rs1_q;
    assign ex_rs2_o    = rs2_q;
    assign ex_rd_o     = rd_q;
    assign ex_ctrl_o   = ctrl_q;
    assign stall_o     = stall;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    localparam logic [7:0] C_LW   = 8'hD8;
    localparam logic [7:0] C_ADD  = 8'h82;
    localparam logic [7:0] C_ADDI = 8'h8A;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             id_valid_i;
    logic [XLEN-1:0]  id_pc_i;
    logic [4:0]       id_rs1_i, id_rs2_i, id_rd_i;
    logic             id_use_rs1_i, id_use_rs2_i;
    logic [XLEN-1:0]  id_rdata1_i, id_rdata2_i, id_imm_i;
    logic [7:0]       id_ctrl_i;
    logic             flush_i, hold_i;
    logic             ex_valid_o;
    logic [XLEN-1:0]  ex_pc_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o;
    logic [4:0]       ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [7:0]       ex_ctrl_o;
    logic             stall_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid_i),
        .id_pc_i      (id_pc_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_rd_i      (id_rd_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .id_rdata1_i  (id_rdata1_i),
        .id_rdata2_i  (id_rdata2_i),
        .id_imm_i     (id_imm_i),
        .id_ctrl_i    (id_ctrl_i),
        .flush_i      (flush_i),
        .hold_i       (hold_i),
        .ex_valid_o   (ex_valid_o),
        .ex_pc_o      (ex_pc_o),
        .ex_rdata1_o  (ex_rdata1_o),
        .ex_rdata2_o  (ex_rdata2_o),
        .ex_imm_o     (ex_imm_o),
        .ex_rs1_o     (ex_rs1_o),
        .ex_rs2_o     (ex_rs2_o),
        .ex_rd_o      (ex_rd_o),
        .ex_ctrl_o    (ex_ctrl_o),
        .stall_o      (stall_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                         input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [7:0] ctrl);
        id_valid_i   = v;
        id_pc_i      = pc;
        id_rs1_i     = rs1;
        id_rs2_i     = rs2;
        id_rd_i      = rd;
        id_use_rs1_i = u1;
        id_use_rs2_i = u2;
        id_rdata1_i  = d1;
        id_rdata2_i  = d2;
        id_imm_i     = imm;
        id_ctrl_i    = ctrl;
        #1;
    endtask

    task automatic drive_lw(input logic [31:0] pc);
        drive(1'b1, pc, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h0, C_LW);
    endtask

    task automatic drive_add_dep(input logic [31:0] pc);
        drive(1'b1, pc, 5'd5, 5'd3, 5'd7, 1'b1, 1'b1, 32'h55, 32'h33, 32'h0, C_ADD);
    endtask

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        hold_i  = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
        tick();
        rst_i = 1'b0;
        check("rst_valid", ex_valid_o, 0);
        check("rst_ctrl", ex_ctrl_o, 0);
        check("rst_rd", ex_rd_o, 0);
        check("rst_pc", ex_pc_o, 0);
        check("rst_cnt", stall_cnt_o, 0);
        check("rst_stall", stall_o, 0);

        // Passthrough: lw x5 then independent add x6,x1,x2
        drive_lw(32'h100);
        tick();
        check("t1_lw_rd", ex_rd_o, 5);
        check("t1_lw_ctrl", ex_ctrl_o, C_LW);
        drive(1'b1, 32'h104, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, C_ADD);
        check("t1_nostall", stall_o, 0);
        tick();
        check("t1_rd", ex_rd_o, 6);
        check("t1_rdata1", ex_rdata1_o, 32'h11);
        check("t1_rdata2", ex_rdata2_o, 32'h22);
        check("t1_valid", ex_valid_o, 1);
        check("t1_pc", ex_pc_o, 32'h104);
        check("t1_ctrl", ex_ctrl_o, C_ADD);
        check("t1_stall_after", stall_o, 0);

        // Load-use: one bubble, then the dependent add loads
        drive_lw(32'h108);
        tick();
        drive_add_dep(32'h10C);
        check("t2_stall", stall_o, 1);
        tick();
        check("t2_bub_valid", ex_valid_o, 0);
        check("t2_bub_ctrl", ex_ctrl_o, 0);
        check("t2_bub_rd", ex_rd_o, 0);
        check("t2_bub_pc", ex_pc_o, 0);
        check("t2_cnt", stall_cnt_o, 1);
        check("t2_stall_drop", stall_o, 0);
        tick();
        check("t2_add_rd", ex_rd_o, 7);
        check("t2_add_rs1", ex_rs1_o, 5);
        check("t2_add_rdata1", ex_rdata1_o, 32'h55);
        check("t2_add_valid", ex_valid_o, 1);
        check("t2_cnt_hold", stall_cnt_o, 1);

        // Flush beats load-use
        drive_lw(32'h110);
        tick();
        drive_add_dep(32'h114);
        flush_i = 1'b1;
        #1;
        check("t3_stall", stall_o, 0);
        tick();
        flush_i = 1'b0;
        check("t3_valid", ex_valid_o, 0);
        check("t3_ctrl", ex_ctrl_o, 0);
        check("t3_rd", ex_rd_o, 0);
        check("t3_rdata1", ex_rdata1_o, 0);
        check("t3_cnt", stall_cnt_o, 1);

        // x0 destination: reg_write dropped
        drive(1'b1, 32'h120, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h5, C_ADDI);
        tick();
        check("t4_ctrl", ex_ctrl_o, C_ADDI & 8'h7F);
        check("t4_rd", ex_rd_o, 0);
        check("t4_imm", ex_imm_o, 5);
        check("t4_valid", ex_valid_o, 1);

        // Hold: EX frozen, stall suppressed, then re-evaluated
        drive(1'b1, 32'h130, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h77, 32'h0, 32'h0, C_LW);
        tick();
        check("t5_pc", ex_pc_o, 32'h130);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_add_dep(32'h134 + 32'(i * 4));
            check("t5_hold_stall", stall_o, 0);
            tick();
            check("t5_hold_pc", ex_pc_o, 32'h130);
            check("t5_hold_ctrl", ex_ctrl_o, C_LW);
            check("t5_hold_rd", ex_rd_o, 5);
            check("t5_hold_rdata1", ex_rdata1_o, 32'h77);
        end
        hold_i = 1'b0;
        drive_add_dep(32'h140);
        check("t5_pending_stall", stall_o, 1);

        // Reset while stalling
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t6_rst_valid", ex_valid_o, 0);
        check("t6_rst_ctrl", ex_ctrl_o, 0);
        check("t6_rst_rd", ex_rd_o, 0);
        check("t6_rst_rs1", ex_rs1_o, 0);
        check("t6_rst_pc", ex_pc_o, 0);
        check("t6_rst_rdata1", ex_rdata1_o, 0);
        check("t6_rst_imm", ex_imm_o, 0);
        check("t6_rst_cnt", stall_cnt_o, 0);
        check("t6_rst_stall", stall_o, 0);

        // Saturation with a 2-bit counter: 1,2,3,3
        for (int i = 0; i < 4; i++) begin
            drive_lw(32'h200 + 32'(i * 8));
            tick();
            drive_add_dep(32'h204 + 32'(i * 8));
            check("t6_sat_stall", stall_o, 1);
            tick();
            check("t6_sat_cnt", stall_cnt_o, (i < 3) ? 64'(i + 1) : 64'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core. It sits directly upstream of the EX-stage forwarding logic.
- Captures the decoded ID-stage operands and controls and presents them to EX. Its rs1/rs2/rd and reg_write outputs are what the forwarding logic compares against later-stage destinations.
- Contains load-use hazard detection and bubble insertion, branch-flush squashing, an external hold, and a saturating stall counter.

Parameters:
- XLEN, 32, datapath width (PC, register data, immediate)
- CNT_W, 16, width of the stall/bubble performance counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  ID instruction PC
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices
- id_use_rs1_i, id_use_rs2_i  in  1 each  instruction actually reads rs1/rs2
- id_rdata1_i, id_rdata2_i  in  XLEN each  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_ctrl_i  in  8  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[1:0]}
- flush_i  in  1  branch taken in EX; squash ID instruction
- hold_i  in  1  downstream (memory) wait; freeze ID/EX
- ex_valid_o  out  1  EX slot holds a real instruction
- ex_pc_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o  out  XLEN each  registered copies
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  registered indices
- ex_ctrl_o  out  8  registered controls, same packing as id_ctrl_i
- stall_o  out  1  load-use stall: freeze PC and IF/ID this cycle
- stall_cnt_o  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset: on a rising clk_i with rst_i=1, all outputs clear to 0 (ex_valid_o=0, ctrl=0, indices=0, data=0, stall_cnt_o=0). Reset has absolute priority and applies mid-stall.
- stall_o is combinational from current EX registers and ID inputs:
  - stall_o = ex_valid_o & ex_ctrl_o.mem_read & ex_rd_o!=0 & id_valid_i & ((id_use_rs1_i & id_rs1_i==ex_rd_o) | (id_use_rs2_i & id_rs2_i==ex_rd_o)) & !flush_i & !hold_i.
- Register update at each clock edge, priority order:
  1. rst_i: clear all.
  2. flush_i: insert a bubble. A bubble sets valid=0, ctrl=0, rs1/rs2/rd=0, and data/imm/pc=0.
  3. hold_i: keep all registers unchanged.
  4. stall_o: insert a bubble and increment stall_cnt_o.
  5. Otherwise load the ID inputs. ex_valid_o takes id_valid_i, and ctrl is zeroed when id_valid_i=0.
- x0 rule: when loading, reg_write in ex_ctrl_o is forced to 0 if id_rd_i==0. The forwarding logic does not check rd!=0 itself.
- Latency: exactly 1 cycle from ID inputs to EX outputs.
- Load-use penalty: exactly 1 bubble. The following cycle holds the bubble in EX, so stall_o deasserts.
- Simultaneous events:
  - flush_i with a load-use match: flush wins, stall_o=0, and the counter is unchanged.
  - hold_i with a match: stall_o=0. The stall is re-evaluated once hold_i drops.
- stall_cnt_o saturates at all ones and never wraps.

Decomposition:
- Shared package (core_pkg) holds:
  - ctrl bit-index constants (CTRL_REG_WRITE=7 … CTRL_ALU_OP=1:0)
  - the ctrl_t packed typedef
  - the BUBBLE_CTRL constant (all zero)
- Sub-module load_use_detect is combinational and produces stall_o. The register and priority logic stay in id_ex_stage.

Test Plan:
1. Passthrough: the ID loads are lw x5 followed by add x6,x1,x2 (rd=6, reg_write=1, data 0x11/0x22). The next cycle shows ex_rd_o=6, ex_rdata1_o=0x11, ex_valid_o=1, stall_o=0 throughout.
2. Load-use: EX holds lw x5 (mem_read=1, rd=5) and ID presents add x7,x5,x3 with use_rs1=1. stall_o=1 for one cycle, the next EX is a bubble (ctrl=0, valid=0), stall_cnt_o=1, and the cycle after loads the add.
3. Flush precedence: same setup as test 2, plus flush_i=1. stall_o=0, the next EX is a bubble, and stall_cnt_o is unchanged.
4. x0 destination: ID presents addi x0,x0,5 with reg_write=1. ex_ctrl_o.reg_write=0 and ex_rd_o=0.
5. Hold: hold_i=1 for 3 cycles while ID changes. EX outputs stay constant and stall_o=0. After the hold, the pending load-use stall asserts.
6. Reset mid-stall and saturation:
   - Assert rst_i while stall_o=1. All outputs are 0 the next cycle.
   - With CNT_W=2, four bubbles give stall_cnt_o=3, not 0.
